// File: rtl/universal_shift_register_pkg.sv
// Shared constants for the universal shift register: mode encodings and defaults.
package universal_shift_register_pkg;

    localparam int unsigned MODE_W        = 2;
    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SHR  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SHL  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load each cycle.
// The register is the only state; data_out is driven straight from it.
module universal_shift_register
    import universal_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] control,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              shift_in_left,
    input  logic              shift_in_right,
    output logic [WIDTH-1:0]  data_out
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_next;

    // Next-value selection; vacated bits come only from the active serial input.
    always_comb begin
        w_next = r_data;
        case (control)
            MODE_HOLD: w_next = r_data;
            MODE_SHR:  w_next = {shift_in_right, r_data[WIDTH-1:1]};
            MODE_SHL:  w_next = {r_data[WIDTH-2:0], shift_in_left};
            MODE_LOAD: w_next = data_in;
            default:   w_next = r_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else begin
            r_data <= w_next;
        end
    end

    assign data_out = r_data;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised self-checking bench for universal_shift_register against an arithmetic reference model.
module tb_universal_shift_register;

    localparam int unsigned W        = 8;
    localparam int unsigned N_RANDOM = 400;

    logic         clk;
    logic         rst;
    logic [1:0]   control;
    logic [W-1:0] data_in;
    logic         shift_in_left;
    logic         shift_in_right;
    logic [W-1:0] data_out;

    logic [W-1:0] model;
    int           n_tests;
    int           n_fail;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .control        (control),
        .data_in        (data_in),
        .shift_in_left  (shift_in_left),
        .shift_in_right (shift_in_right),
        .data_out       (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour as plain arithmetic on an unsigned value.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic [1:0] c,
                                              input logic [W-1:0] d, input logic sl, input logic sr);
        int unsigned v;
        v = int'(cur);
        case (c)
            2'd1:    v = (v / 2) + (sr ? (1 << (W - 1)) : 0);
            2'd2:    v = ((v * 2) % (1 << W)) + (sl ? 1 : 0);
            2'd3:    v = int'(d);
            default: v = int'(cur);
        endcase
        return W'(v);
    endfunction

    // Apply one operation, clock it, then compare DUT with the model.
    task automatic do_op(input string tag, input logic [1:0] c, input logic [W-1:0] d,
                         input logic sl, input logic sr);
        control        = c;
        data_in        = d;
        shift_in_left  = sl;
        shift_in_right = sr;
        @(posedge clk);
        model = ref_next(model, c, d, sl, sr);
        #1;
        check(tag, data_out, model);
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b0;
        model = '0;
        #1;
        check(tag, data_out, '0);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        model          = '0;
        rst            = 1'b0;
        control        = 2'b11;
        data_in        = 8'hFF;
        shift_in_left  = 1'b1;
        shift_in_right = 1'b1;

        // Reset held with clock running and a load requested: must stay clear.
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", data_out, 8'h00);
        control = 2'b00;
        rst     = 1'b1;
        #1;
        check("reset_release", data_out, 8'h00);

        do_op("first_hold", 2'b00, 8'hFF, 1'b1, 1'b1);
        check("first_hold_const", data_out, 8'h00);
        do_op("load_aa", 2'b11, 8'hAA, 1'b1, 1'b0);
        check("load_aa_const", data_out, 8'hAA);
        do_op("shr_in1", 2'b01, 8'h00, 1'b0, 1'b1);
        check("shr_in1_const", data_out, 8'hD5);
        do_op("shl_in0", 2'b10, 8'hFF, 1'b0, 1'b1);
        check("shl_in0_const", data_out, 8'hAA);
        do_op("hold", 2'b00, 8'h0F, 1'b1, 1'b1);
        check("hold_const", data_out, 8'hAA);
        do_op("shr_in0", 2'b01, 8'hFF, 1'b1, 1'b0);
        check("shr_in0_const", data_out, 8'h55);

        // No wrap-around: MSB leaving on shift left is lost.
        do_op("load_80", 2'b11, 8'h80, 1'b0, 1'b0);
        do_op("shl_nowrap", 2'b10, 8'h00, 1'b0, 1'b1);
        check("shl_nowrap_const", data_out, 8'h00);
        do_op("load_01", 2'b11, 8'h01, 1'b0, 1'b0);
        do_op("shr_nowrap", 2'b01, 8'h00, 1'b1, 1'b0);
        check("shr_nowrap_const", data_out, 8'h00);

        do_op("load_ff", 2'b11, 8'hFF, 1'b0, 1'b0);
        reset_pulse("mid_reset");
        do_op("post_reset_load", 2'b11, 8'h3C, 1'b0, 1'b0);
        check("post_reset_load_const", data_out, 8'h3C);

        for (int i = 0; i < N_RANDOM; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                reset_pulse("rand_reset");
            end
            do_op("rand_op", 2'($urandom_range(0, 3)), W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits (SHALL be >= 2).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous active-low reset.
REQ-005 Port: control  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 Port: data_in  input  WIDTH  parallel load data.
REQ-007 Port: shift_in_left  input  1  serial bit entering LSB on shift left.
REQ-008 Port: shift_in_right  input  1  serial bit entering MSB on shift right.
REQ-009 Port: data_out  output  WIDTH  current register contents, driven directly from the register.

Function
REQ-010 The register SHALL update only on rising clk while rst is high.
REQ-011 control=00: the register SHALL hold its value.
REQ-012 control=01: data_out SHALL become {shift_in_right, data_out[WIDTH-1:1]}; the LSB is discarded.
REQ-013 control=10: data_out SHALL become {data_out[WIDTH-2:0], shift_in_left}; the MSB is discarded.
REQ-014 control=11: data_out SHALL become data_in.
REQ-015 Latency SHALL be one cycle: the new value is visible after the sampling edge.
REQ-016 control, data_in and both serial inputs SHALL be sampled only at the rising edge.
REQ-017 The serial input not used by the current mode SHALL be ignored.
REQ-018 No handshake is required: every cycle is an accepted operation.
REQ-019 Shifts SHALL not wrap around; vacated bits come only from the serial input.
REQ-020 There SHALL be no other state machine: the register itself is the only state.

Reset
REQ-021 While rst is low, data_out SHALL be all zeros, cleared immediately without waiting for clk.
REQ-022 Reset asserted mid-operation SHALL override any mode; the pending operation is lost.
REQ-023 After rst deasserts, the first rising edge SHALL perform the operation selected by control.

Structure
REQ-024 The 2-bit mode encodings (HOLD, SHR, SHL, LOAD) SHALL be named constants in a shared package, universal_shift_register_pkg.
REQ-025 The design SHALL be a single module with no sub-modules: one sequential process plus next-state selection.

Verification
REQ-026 Hold rst low with clk running -> data_out=00000000; release -> still 00000000 until an operation.
REQ-027 Load with control=11, data_in=10101010 -> 10101010.
REQ-028 Shift right: control=01, shift_in_right=1 -> 11010101.
REQ-029 Shift left: control=10, shift_in_left=0 -> 10101010.
REQ-030 Hold with control=00 -> 10101010 unchanged.
REQ-031 Shift right: control=01, shift_in_right=0 -> 01010101.
REQ-032 Pulse rst low between edges -> 00000000 immediately.
